// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands DIGIT bits per
// cycle, MSB first, and reports gt/eq/lt with a start/busy/done handshake.
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("seq_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d;
    logic             agtb_q, agtb_d;
    logic             aeqb_q, aeqb_d;
    logic             altb_q, altb_d;

    logic [DIGIT-1:0] dig_a, dig_b;
    logic [WIDTH-1:0] msb_flip;

    assign dig_a = a_q[WIDTH-1 -: DIGIT];
    assign dig_b = b_q[WIDTH-1 -: DIGIT];
    // Flipping the sign bit maps two's complement onto offset binary, so the
    // digit walk below is always an unsigned compare.
    assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        agtb_d    = agtb_q;
        aeqb_d    = aeqb_q;
        altb_d    = altb_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a ^ msb_flip;
                    b_d       = b ^ msb_flip;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // First differing digit decides; later digits are don't-care.
                if (!decided_q && (dig_a != dig_b)) begin
                    decided_d = 1'b1;
                    gt_d      = (dig_a > dig_b);
                end
                a_d   = a_q << DIGIT;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    agtb_d  = decided_d & gt_d;
                    altb_d  = decided_d & ~gt_d;
                    aeqb_d  = ~decided_d;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            agtb_q    <= 1'b0;
            aeqb_q    <= 1'b0;
            altb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            agtb_q    <= agtb_d;
            aeqb_q    <= aeqb_d;
            altb_q    <= altb_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign agtb = agtb_q;
    assign aeqb = aeqb_q;
    assign altb = altb_q;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: three instances (16/4, 4/1, 8/8) checked every
// cycle against an integer-compare model with start-to-done timing.
module tb_seq_mag_comparator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_i[3];
    logic        sm_i[3];
    logic [15:0] a_i[3];
    logic [15:0] b_i[3];
    logic        busy_o[3], done_o[3], gt_o[3], eq_o[3], lt_o[3];
    logic        exp_busy[3], exp_done[3];
    logic [2:0]  exp_res[3];

    int total = 0;
    int bad   = 0;

    function automatic int wid(input int i);
        return (i == 0) ? 16 : (i == 1) ? 4 : 8;
    endfunction
    function automatic int dig(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 8;
    endfunction
    function automatic int nn(input int i);
        return wid(i) / dig(i);
    endfunction

    // {gt, eq, lt} from a plain integer compare of the low w bits.
    function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                           input logic sm, input int w);
        longint va, vb;
        va = longint'(a);
        vb = longint'(b);
        if (sm && a[w-1]) va = va - (longint'(1) << w);
        if (sm && b[w-1]) vb = vb - (longint'(1) << w);
        if (va > vb) return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 16 : (g == 1) ? 4 : 8;
        localparam int D = (g == 0) ? 4 : (g == 1) ? 1 : 8;
        localparam int N = W / D;

        seq_mag_comparator #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start_i[g]),
            .signed_mode(sm_i[g]),
            .a          (a_i[g][W-1:0]),
            .b          (b_i[g][W-1:0]),
            .busy       (busy_o[g]),
            .done       (done_o[g]),
            .agtb       (gt_o[g]),
            .aeqb       (eq_o[g]),
            .altb       (lt_o[g])
        );

        // Model: m_cnt counts edges since an accepted start (0 = idle).
        int         m_cnt;
        logic [2:0] m_pend, m_res;
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                m_cnt <= 0;
                m_res <= 3'b000;
            end else if (m_cnt == 0) begin
                if (start_i[g]) begin
                    m_cnt  <= 1;
                    m_pend <= ref_cmp(16'(a_i[g][W-1:0]), 16'(b_i[g][W-1:0]), sm_i[g], W);
                end
            end else if (m_cnt == N + 1) begin
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == N) m_res <= m_pend;
            end
        end
        assign exp_busy[g] = (m_cnt >= 1) && (m_cnt <= N);
        assign exp_done[g] = (m_cnt == N + 1);
        assign exp_res[g]  = m_res;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({busy_o[i], done_o[i], gt_o[i], eq_o[i], lt_o[i]} !==
                {exp_busy[i], exp_done[i], exp_res[i]}) begin
                bad++;
                $display("FAIL cycle[%0d] got busy/done/gel=%b%b%b%b%b want=%b%b%b t=%0t", i,
                         busy_o[i], done_o[i], gt_o[i], eq_o[i], lt_o[i],
                         exp_busy[i], exp_done[i], exp_res[i], $time);
            end
            if (done_o[i] === 1'b1) begin
                total++;
                if ($countones({gt_o[i], eq_o[i], lt_o[i]}) != 1) begin
                    bad++;
                    $display("FAIL onehot[%0d] got=%b%b%b want exactly one set", i,
                             gt_o[i], eq_o[i], lt_o[i]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
        end
    endtask

    // Called at a negedge with start already high; returns one negedge after done.
    task automatic wait_done(input int i, output logic [2:0] res);
        int e;
        @(negedge clk);
        start_i[i] = 1'b0;
        a_i[i] = 16'($urandom);
        b_i[i] = 16'($urandom);
        e = 1;
        while (done_o[i] !== 1'b1 && e < 40) begin
            @(negedge clk);
            e++;
        end
        chk("latency", e, nn(i) + 1);
        res = {gt_o[i], eq_o[i], lt_o[i]};
        @(negedge clk);
    endtask

    task automatic run(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, output logic [2:0] res);
        start_i[i] = 1'b1;
        a_i[i]     = a;
        b_i[i]     = b;
        sm_i[i]    = sm;
        wait_done(i, res);
    endtask

    initial begin
        logic [2:0]  r;
        logic [15:0] ra, rb;
        int          dones, k;
        for (int i = 0; i < 3; i++) begin
            start_i[i] = 1'b0;
            sm_i[i]    = 1'b0;
            a_i[i]     = '0;
            b_i[i]     = '0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("reset_state", {busy_o[0], done_o[0], gt_o[0], eq_o[0], lt_o[0]}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run(0, 16'h8000, 16'h7FFF, 1'b0, r); chk("u_8000_7fff", r, 3'b100);
        run(0, 16'h8000, 16'h7FFF, 1'b1, r); chk("s_8000_7fff", r, 3'b001);
        run(0, 16'hFFFF, 16'h0001, 1'b1, r); chk("s_ffff_0001", r, 3'b001);
        run(0, 16'hA5A5, 16'hA5A5, 1'b0, r); chk("u_eq_a5a5",   r, 3'b010);
        run(0, 16'hA5A5, 16'hA5A5, 1'b1, r); chk("s_eq_a5a5",   r, 3'b010);
        run(0, 16'h1234, 16'h1235, 1'b0, r); chk("u_last_dig",  r, 3'b001);
        run(2, 16'h0080, 16'h007F, 1'b1, r); chk("n1_signed",   r, 3'b001);

        // Start held high through the whole compare with operands churning.
        start_i[0] = 1'b1; a_i[0] = 16'h0003; b_i[0] = 16'h0002; sm_i[0] = 1'b0;
        dones = 0;
        r = 3'b000;
        for (k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) begin
                dones++;
                r = {gt_o[0], eq_o[0], lt_o[0]};
            end
            a_i[0] = 16'($urandom); b_i[0] = 16'($urandom); sm_i[0] = 1'($urandom);
        end
        chk("busy_start_dones", dones, 1);
        chk("busy_start_res", r, 3'b100);
        a_i[0] = 16'h0001; b_i[0] = 16'h0002; sm_i[0] = 1'b0;
        wait_done(0, r);
        chk("restart_after_done", r, 3'b001);

        // Reset during the second RUN cycle.
        start_i[0] = 1'b1; a_i[0] = 16'h00FF; b_i[0] = 16'h0F00; sm_i[0] = 1'b0;
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_run", {busy_o[0], done_o[0], gt_o[0], eq_o[0], lt_o[0]}, 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) dones++;
        end
        chk("rst_no_done", dones, 0);
        run(0, 16'h00FF, 16'h0F00, 1'b0, r); chk("after_reset", r, 3'b001);

        for (int sm = 0; sm < 2; sm++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run(1, 16'(x), 16'(y), 1'(sm), r);

        for (int it = 0; it < 150; it++) begin
            int i;
            i  = int'($urandom_range(0, 2));
            ra = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = 16'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (16'h1 << $urandom_range(0, wid(i) - 1));
            endcase
            run(i, ra, rb, 1'($urandom), r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
